rr_req_ctrl: RTL and testbench
==============================

# rr_req_ctrl

- Requester-side controller for the 4-way round-robin arbiter.
- Per client, it queues transaction requests, drives that client's `REQ` line, and waits for `GNT`. Once granted, it holds ownership for a fixed burst, then releases `REQ` so the arbiter can rotate.
- It sits between client logic and the arbiter's `REQ`/`GNT` pair. It also checks that grant behaviour is legal.

## Interface
- `N`, 4, number of clients; matches the arbiter width.
- `BURST_LEN`, 4, cycles of ownership per granted transaction (≥1).
- `CNT_W`, 3, width of each client's pending-transaction counter; max pending is 2^CNT_W−1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `push`  in  N  bit i high for one cycle enqueues one transaction for client i.
- `full`  out  N  bit i high when client i's pending count equals 2^CNT_W−1.
- `REQ`  out  N  request lines to the arbiter.
- `GNT`  in  N  grant lines from the arbiter.
- `busy`  out  N  bit i high while client i owns the bus (XFER state).
- `done`  out  N  bit i pulses for one cycle on client i's last burst beat.
- `err`  out  1  sticky protocol-error flag.

## Operation
Each client i has:
- an independent FSM: IDLE, WAIT, XFER, REL;
- a pending counter `pend[i]` (CNT_W bits);
- a beat counter (width ceil(log2(BURST_LEN+1))).

Pending counter:
- `push[i]` with `full[i]`=0: `pend[i]`+1.
- `push[i]` with `full[i]`=1: the push is dropped; `pend[i]` is unchanged; no error is raised.
- Completion (last XFER beat): `pend[i]`−1.
- `push[i]` coincident with completion: net change 0. This applies even when full.

FSM transitions:
- IDLE → WAIT when `pend[i]`≠0.
- WAIT → XFER when `GNT[i]`=1 is sampled. The beat counter loads 1.
- XFER: the beat counter increments each cycle.
  - When beat=BURST_LEN: `done[i]`=1, decrement `pend[i]`, go to REL.
- REL → WAIT if `pend[i]` (after that edge's update) ≠0, else → IDLE. REL lasts exactly one cycle.

Outputs:
- `REQ[i]`=1 in WAIT and XFER; 0 in IDLE and REL.
- `busy[i]`=1 only in XFER.
- All outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.

Protocol checks (set `err`, which stays 1 until reset):
- grant without request: `GNT[i]`=1 while client i is in IDLE or REL;
- multiple grants: `GNT` has more than one bit set in a cycle;
- preemption: `GNT[i]` drops to 0 while in XFER and beat<BURST_LEN.

Error behaviour:
- An error does not alter FSM behaviour.
- On preemption, the client still completes its burst count.

## Timing
- Reset values: `REQ`=0, `busy`=0, `done`=0, `full`=0, `err`=0, all FSMs IDLE, all counters 0.
- Reset mid-burst aborts immediately, with no `done` pulse.
- `push[i]` at edge k → `pend[i]`=1 after edge k → IDLE→WAIT at edge k+1 → `REQ[i]`=1 during cycle k+1.
- `GNT[i]` sampled high at edge g → `busy[i]`=1 from g.
- `done[i]` is high during the cycle following edge g+BURST_LEN−1.
- `REQ[i]` is low for exactly one cycle (REL) after each burst. This guarantees the arbiter sees a request drop before the next transaction from the same client.
- Back-to-back transactions from one client: the period is BURST_LEN+1 (XFER+REL), plus WAIT time for arbitration.

## Configuration
- `RR_REQ_ERRCHK_EN` defined: protocol checks and sticky `err` are built as specified.
- `RR_REQ_ERRCHK_EN` undefined: check logic is omitted, `err` is tied to 0, and all other behaviour is identical.

## Test plan
- Reset: drive `rst`=0 mid-burst with `pend[2]`=3 → all outputs 0 immediately; after release, `REQ`=0 until a new push.
- Single client: `push`=4'b0001 once; bench grants `GNT`=4'b0001 one cycle after `REQ[0]` rises.
  - Required: `busy[0]` high for 4 cycles, one `done[0]` pulse, `REQ[0]` low in the REL cycle and afterward, `pend[0]`=0.
- Full/drop: push client 1 eight times with no grant.
  - Required: `full[1]`=1 after the 7th push, the 8th push is dropped, and exactly 7 `done[1]` pulses occur after granting.
- Simultaneous push and completion: with client 3 full, push on its last beat → `pend[3]` stays 7 and `full[3]` stays 1.
- Round-robin interplay: `push`=4'b1111 with a reference arbiter model → each client gets exactly one burst, `GNT` is one-hot at all times, `err`=0.
- Error checks (macro defined):
  - `GNT`=4'b0100 with client 2 IDLE → `err`=1 next cycle, held until reset.
  - `GNT`=4'b0011 → `err`=1.
  - Undefined-macro build with the same stimulus → `err`=0.

Source files
------------

// File: rtl/rr_req_ctrl.sv
// rtl/rr_req_ctrl.sv - per-client requester controller for a 4-way round-robin arbiter
// Optional protocol checking is built when RR_REQ_ERRCHK_EN is defined; otherwise err is tied low.

module rr_req_ctrl #(
  parameter int N         = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] push,
  output logic [N-1:0] full,
  output logic [N-1:0] REQ,
  input  logic [N-1:0] GNT,
  output logic [N-1:0] busy,
  output logic [N-1:0] done,
  output logic         err
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [CNT_W-1:0]  PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  PEND_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  state_t            state_q [N];
  state_t            state_d [N];
  logic [CNT_W-1:0]  pend_q  [N];
  logic [CNT_W-1:0]  pend_d  [N];
  logic [BEAT_W-1:0] beat_q  [N];
  logic [BEAT_W-1:0] beat_d  [N];

  logic [N-1:0] last_beat;
  logic [N-1:0] pend_full;
  logic [N-1:0] pend_inc;

  // Per-client status decoded from registered state: last burst beat, queue full
  always_comb begin
    last_beat = '0;
    pend_full = '0;
    for (int i = 0; i < N; i++) begin
      last_beat[i] = (state_q[i] == ST_XFER) && (beat_q[i] == LAST_BEAT);
      pend_full[i] = (pend_q[i] == PEND_MAX);
    end
  end

  // State register: FSM, pending counter and beat counter per client
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_IDLE;
        pend_q[i]  <= '0;
        beat_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        pend_q[i]  <= pend_d[i];
        beat_q[i]  <= beat_d[i];
      end
    end
  end

  // Next-state: queue accounting first, since REL exit looks at the updated count
  always_comb begin
    pend_inc = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      pend_d[i]  = pend_q[i];
      beat_d[i]  = beat_q[i];

      // A push while full is only accepted when a completion frees a slot on the same edge
      pend_inc[i] = push[i] && (!pend_full[i] || last_beat[i]);
      if (pend_inc[i] && !last_beat[i]) begin
        pend_d[i] = pend_q[i] + PEND_ONE;
      end else if (!pend_inc[i] && last_beat[i]) begin
        pend_d[i] = pend_q[i] - PEND_ONE;
      end

      case (state_q[i])
        ST_IDLE: begin
          if (pend_q[i] != '0) begin
            state_d[i] = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (GNT[i]) begin
            state_d[i] = ST_XFER;
            beat_d[i]  = BEAT_ONE;
          end
        end
        ST_XFER: begin
          // The burst always runs to its full length, even if the grant is pulled early
          if (last_beat[i]) begin
            state_d[i] = ST_REL;
            beat_d[i]  = '0;
          end else begin
            beat_d[i]  = beat_q[i] + BEAT_ONE;
          end
        end
        ST_REL: begin
          state_d[i] = (pend_d[i] != '0) ? ST_WAIT : ST_IDLE;
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs: pure decode of registered state, no input-to-output paths
  always_comb begin
    REQ  = '0;
    busy = '0;
    done = '0;
    full = '0;
    for (int i = 0; i < N; i++) begin
      REQ[i]  = (state_q[i] == ST_WAIT) || (state_q[i] == ST_XFER);
      busy[i] = (state_q[i] == ST_XFER);
      done[i] = last_beat[i];
      full[i] = pend_full[i];
    end
  end

`ifdef RR_REQ_ERRCHK_EN
  logic         err_q;
  logic         err_d;
  logic [N-1:0] gnt_no_req;
  logic [N-1:0] preempt;
  logic         multi_gnt;

  // Protocol checks against the arbiter; the flag is sticky until reset
  always_comb begin
    gnt_no_req = '0;
    preempt    = '0;
    for (int i = 0; i < N; i++) begin
      gnt_no_req[i] = GNT[i] && ((state_q[i] == ST_IDLE) || (state_q[i] == ST_REL));
      preempt[i]    = !GNT[i] && (state_q[i] == ST_XFER) && (beat_q[i] < LAST_BEAT);
    end
    multi_gnt = (GNT & (GNT - {{(N-1){1'b0}}, 1'b1})) != '0;
    err_d     = err_q || (|gnt_no_req) || (|preempt) || multi_gnt;
  end

  // Sticky error register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_ctrl.sv
// tb/tb_rr_req_ctrl.sv - scoreboard bench for rr_req_ctrl
module tb_rr_req_ctrl;

  localparam int N  = 4;
  localparam int BL = 4;
`ifdef RR_REQ_ERRCHK_EN
  localparam int ERRCHK = 1;
`else
  localparam int ERRCHK = 0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] push;
  logic [N-1:0] full;
  logic [N-1:0] REQ;
  logic [N-1:0] GNT;
  logic [N-1:0] busy;
  logic [N-1:0] done;
  logic         err;

  logic [N-1:0] arb_gnt;
  logic [N-1:0] man_gnt;
  logic         arb_en;
  bit           hot_chk;

  int checks;
  int errors;
  int sb_q[$];
  int bcnt[N];

  assign GNT = arb_en ? arb_gnt : man_gnt;

  rr_req_ctrl #(.N(N), .BURST_LEN(BL), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .push(push),
    .full(full),
    .REQ (REQ),
    .GNT (GNT),
    .busy(busy),
    .done(done),
    .err (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || REQ != '0) && n < limit) begin
      tick();
      n++;
    end
    check(name, int'(sb_q.size() == 0 && REQ == '0), 1);
  endtask

  // Reference round-robin arbiter: grants a client once its request has been seen for
  // a full cycle, holds the grant while the owner keeps REQ high, rotates from the last owner
  initial begin
    int owner;
    int ptr;
    logic [N-1:0] req_prev;
    bit found;
    owner    = -1;
    ptr      = 0;
    req_prev = '0;
    arb_gnt  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || !arb_en) begin
        owner   = -1;
        if (!rst) ptr = 0;
        arb_gnt = '0;
        req_prev = rst ? REQ : '0;
      end else begin
        if (owner >= 0 && !REQ[owner]) owner = -1;
        if (owner < 0) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (!found && REQ[j] && req_prev[j]) begin
              owner = j;
              ptr   = (j + 1) % N;
              found = 1;
            end
          end
        end
        arb_gnt  = (owner >= 0) ? (N'(1) << owner) : '0;
        req_prev = REQ;
      end
    end
  end

  // Monitor: every done pulse pops the next expected completion and checks burst length
  initial begin
    int exp_id;
    for (int i = 0; i < N; i++) bcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (busy[i]) bcnt[i]++;
        else bcnt[i] = 0;
        if (done[i]) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done on client %0d, required no pending completion at %0t", i, $time);
          end else begin
            exp_id = sb_q.pop_front();
            check("done_client", i, exp_id);
            check("burst_len", bcnt[i], BL);
          end
        end
      end
      if (hot_chk) check("busy_onehot", int'($countones(busy) <= 1), 1);
    end
  end

  initial begin
    int n;
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    push    = '0;
    man_gnt = '0;
    arb_en  = 1'b0;
    hot_chk = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req",  int'(REQ),  0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_full", int'(full), 0);
    check("rst_err",  int'(err),  0);
    rst = 1'b1;
    tick();

    // Single client 0
    arb_en = 1'b1;
    push = 4'b0001;
    sb_q.push_back(0);
    tick();
    push = '0;
    check("single_req_idle", int'(REQ), 0);
    tick();
    check("single_req_wait", int'(REQ), 1);
    tick();
    check("single_busy_wait", int'(busy), 0);
    tick();
    check("single_busy_xfer", int'(busy), 1);
    tick();
    tick();
    tick();
    check("single_done", int'(done), 1);
    tick();
    check("single_req_rel", int'(REQ), 0);
    check("single_busy_rel", int'(busy), 0);
    tick();
    check("single_req_after", int'(REQ), 0);
    check("single_full", int'(full), 0);

    // Fill client 1 with eight pushes, no grant
    arb_en  = 1'b0;
    man_gnt = '0;
    push    = 4'b0010;
    for (int p = 1; p <= 8; p++) begin
      tick();
      check("fill_full1", int'(full[1]), int'(p >= 7));
    end
    push = '0;
    for (int p = 0; p < 7; p++) sb_q.push_back(1);
    arb_en = 1'b1;
    wait_drain("drain_client1", 200);
    check("drain_full1", int'(full), 0);

    // Client 3 full, push coincident with completion
    arb_en = 1'b0;
    push   = 4'b1000;
    for (int p = 0; p < 7; p++) begin
      tick();
      sb_q.push_back(3);
    end
    push = '0;
    check("fill_full3", int'(full[3]), 1);
    arb_en = 1'b1;
    n = 0;
    while (!done[3] && n < 30) begin
      tick();
      n++;
    end
    check("sim_done_seen", int'(done[3]), 1);
    push = 4'b1000;
    sb_q.push_back(3);
    tick();
    push = '0;
    check("sim_full_hold", int'(full[3]), 1);
    check("sim_busy_rel", int'(busy[3]), 0);
    tick();
    check("sim_full_hold2", int'(full[3]), 1);
    wait_drain("drain_client3", 250);
    check("drain_full3", int'(full), 0);

    // Reset mid-burst with client 2 holding three pending
    push = 4'b0100;
    for (int p = 0; p < 3; p++) begin
      tick();
      sb_q.push_back(2);
    end
    push = '0;
    n = 0;
    while (!busy[2] && n < 30) begin
      tick();
      n++;
    end
    check("mid_busy_seen", int'(busy[2]), 1);
    tick();
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_req",  int'(REQ),  0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_full", int'(full), 0);
    check("mid_rst_err",  int'(err),  0);
    tick();
    tick();
    rst = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick();
      check("post_rst_req", int'(REQ), 0);
    end

    // All four clients at once under the reference arbiter
    hot_chk = 1'b1;
    push = 4'b1111;
    sb_q.push_back(0);
    sb_q.push_back(1);
    sb_q.push_back(2);
    sb_q.push_back(3);
    tick();
    push = '0;
    wait_drain("drain_rr", 100);
    hot_chk = 1'b0;
    check("rr_err", int'(err), 0);

    // Grant to an idle client
    arb_en  = 1'b0;
    man_gnt = 4'b0100;
    tick();
    man_gnt = '0;
    check("err_gnt_no_req", int'(err), ERRCHK);
    tick();
    tick();
    tick();
    check("err_sticky", int'(err), ERRCHK);
    do_reset();
    check("err_cleared", int'(err), 0);

    // Two grants while clients 0 and 1 both wait
    push = 4'b0011;
    tick();
    push = '0;
    tick();
    check("multi_req", int'(REQ), 3);
    check("multi_err_before", int'(err), 0);
    man_gnt = 4'b0011;
    sb_q.push_back(0);
    sb_q.push_back(1);
    tick();
    man_gnt = '0;
    check("err_multi_gnt", int'(err), ERRCHK);
    wait_drain("drain_multi", 40);
    do_reset();

    // Grant withdrawn mid-burst
    push = 4'b0001;
    tick();
    push = '0;
    tick();
    check("pre_req", int'(REQ), 1);
    man_gnt = 4'b0001;
    sb_q.push_back(0);
    tick();
    check("err_legal_grant", int'(err), 0);
    man_gnt = '0;
    tick();
    check("err_preempt", int'(err), ERRCHK);
    check("pre_busy_cont", int'(busy[0]), 1);
    wait_drain("drain_preempt", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
